// File: rtl/dbg_pkg.sv
// Shared types and constants for the bus debug master: FSM states, frame opcodes,
// response codes and the assembled command payload.
package dbg_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_REQ,
    ST_ACCESS,
    ST_RESP
  } state_e;

  localparam logic [BYTE_W-1:0] OP_WRITE = 8'h57;
  localparam logic [BYTE_W-1:0] OP_READ  = 8'h52;
  localparam logic [BYTE_W-1:0] RSP_ACK  = 8'h4B;
  localparam logic [BYTE_W-1:0] RSP_ERR  = 8'h45;

  typedef struct packed {
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
    logic              is_write;
  } cmd_t;

endpackage

// File: rtl/bus_debug_master_if.sv
// Byte-stream and memory-bus signals of the debug master; master = block view,
// slave = environment view (UART side, processor arbiter and peripherals).
interface bus_debug_master_if;

  logic [dbg_pkg::BYTE_W-1:0] rx_data;
  logic                       rx_valid;
  logic                       rx_ready;
  logic [dbg_pkg::BYTE_W-1:0] tx_data;
  logic                       tx_valid;
  logic                       tx_ready;
  logic                       bus_req;
  logic                       bus_gnt;
  logic                       MemRead;
  logic                       MemWrite;
  logic [dbg_pkg::WORD_W-1:0] Address;
  logic [dbg_pkg::WORD_W-1:0] Write_data;
  logic [dbg_pkg::WORD_W-1:0] Read_data;

  modport master (
    input  rx_data, rx_valid, tx_ready, bus_gnt, Read_data,
    output rx_ready, tx_data, tx_valid, bus_req, MemRead, MemWrite, Address, Write_data
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, bus_gnt, Read_data,
    input  rx_ready, tx_data, tx_valid, bus_req, MemRead, MemWrite, Address, Write_data
  );

endinterface

// File: rtl/dbg_resp_tx.sv
// Response serializer: loads up to 4 bytes (MSB first) and streams them out on a
// valid/ready byte interface, flagging the final handshake to the parent FSM.
module dbg_resp_tx
  import dbg_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [WORD_W-1:0] data_i,
  input  logic [CNT_W-1:0]  count_i,
  input  logic              tx_ready_i,
  output logic [BYTE_W-1:0] tx_data_o,
  output logic              tx_valid_o,
  output logic              done_c
);

  logic [WORD_W-1:0] shift_q;
  logic [CNT_W-1:0]  left_q;
  logic              valid_q;
  logic              fire_c;

  assign fire_c = valid_q && tx_ready_i;
  assign done_c = fire_c && (left_q == CNT_W'(1));

  // tx_data is the top byte of the shift register, so it cannot move while stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q <= '0;
      left_q  <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      shift_q <= data_i;
      left_q  <= count_i;
      valid_q <= (count_i != '0);
    end else if (fire_c) begin
      shift_q <= {shift_q[WORD_W-BYTE_W-1:0], BYTE_W'(0)};
      left_q  <= left_q - CNT_W'(1);
      valid_q <= (left_q != CNT_W'(1));
    end
  end

  assign tx_data_o  = shift_q[WORD_W-1 -: BYTE_W];
  assign tx_valid_o = valid_q;

endmodule

// File: rtl/bus_debug_master.sv
// Debug bus initiator: parses read/write command frames from a byte stream, runs one
// bus access after a request/grant handshake and returns a response. Optional
// inter-byte timeout enabled by defining DBG_TIMEOUT_EN.
module bus_debug_master
  import dbg_pkg::*;
`ifdef DBG_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYCLES = 32'd1_000_000
)
`endif
(
  input  logic                clk,
  input  logic                rst,
  bus_debug_master_if.master  bus
);

  state_e            state_q;
  cmd_t              cmd_q;
  logic [1:0]        byte_cnt_q;
  logic              rx_ready_q;
  logic              bus_req_q;
  logic              mem_read_q;
  logic              mem_write_q;

  logic              rx_fire_c;
  logic              last_byte_c;
  logic              is_op_c;
  logic              timeout_c;
  logic              done_c;
  logic              load_c;
  logic [WORD_W-1:0] load_data_c;
  logic [CNT_W-1:0]  load_cnt_c;

  assign rx_fire_c   = bus.rx_valid && rx_ready_q;
  assign last_byte_c = byte_cnt_q == 2'd3;
  assign is_op_c     = (bus.rx_data == OP_WRITE) || (bus.rx_data == OP_READ);

`ifdef DBG_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt_q;
  logic            in_frame_c;

  assign in_frame_c = (state_q == ST_ADDR) || (state_q == ST_DATA);
  assign timeout_c  = in_frame_c && !rx_fire_c && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  // Counts idle cycles between bytes of a frame; any accepted byte restarts it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt_q <= '0;
    end else if (in_frame_c && !rx_fire_c && !timeout_c) begin
      to_cnt_q <= to_cnt_q + TO_W'(1);
    end else begin
      to_cnt_q <= '0;
    end
  end
`else
  assign timeout_c = 1'b0;
`endif

  // Response source: error code on a bad opcode, ack or captured Read_data after the access.
  always_comb begin
    load_c      = 1'b0;
    load_data_c = '0;
    load_cnt_c  = '0;
    if (state_q == ST_IDLE && rx_fire_c && !is_op_c) begin
      load_c      = 1'b1;
      load_data_c = {RSP_ERR, (WORD_W-BYTE_W)'(0)};
      load_cnt_c  = CNT_W'(1);
    end else if (state_q == ST_ACCESS) begin
      load_c      = 1'b1;
      load_data_c = cmd_q.is_write ? {RSP_ACK, (WORD_W-BYTE_W)'(0)} : bus.Read_data;
      load_cnt_c  = cmd_q.is_write ? CNT_W'(1) : CNT_W'(4);
    end
  end

  dbg_resp_tx u_resp_tx (
    .clk       (clk),
    .rst       (rst),
    .load_i    (load_c),
    .data_i    (load_data_c),
    .count_i   (load_cnt_c),
    .tx_ready_i(bus.tx_ready),
    .tx_data_o (bus.tx_data),
    .tx_valid_o(bus.tx_valid),
    .done_c    (done_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      byte_cnt_q  <= '0;
      rx_ready_q  <= 1'b0;
      bus_req_q   <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          rx_ready_q <= 1'b1;
          byte_cnt_q <= '0;
          if (rx_fire_c) begin
            if (is_op_c) begin
              cmd_q.is_write <= (bus.rx_data == OP_WRITE);
              state_q        <= ST_ADDR;
            end else begin
              rx_ready_q <= 1'b0;
              state_q    <= ST_RESP;
            end
          end
        end
        ST_ADDR: begin
          if (timeout_c) begin
            byte_cnt_q <= '0;
            state_q    <= ST_IDLE;
          end else if (rx_fire_c) begin
            cmd_q.addr <= {cmd_q.addr[WORD_W-BYTE_W-1:0], bus.rx_data};
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (last_byte_c) begin
              if (cmd_q.is_write) begin
                state_q <= ST_DATA;
              end else begin
                rx_ready_q <= 1'b0;
                bus_req_q  <= 1'b1;
                state_q    <= ST_REQ;
              end
            end
          end
        end
        ST_DATA: begin
          if (timeout_c) begin
            byte_cnt_q <= '0;
            state_q    <= ST_IDLE;
          end else if (rx_fire_c) begin
            cmd_q.wdata <= {cmd_q.wdata[WORD_W-BYTE_W-1:0], bus.rx_data};
            byte_cnt_q  <= byte_cnt_q + 2'd1;
            if (last_byte_c) begin
              rx_ready_q <= 1'b0;
              bus_req_q  <= 1'b1;
              state_q    <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (bus.bus_gnt) begin
            mem_read_q  <= !cmd_q.is_write;
            mem_write_q <= cmd_q.is_write;
            state_q     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          bus_req_q <= 1'b0;
          state_q   <= ST_RESP;
        end
        ST_RESP: begin
          if (done_c) begin
            rx_ready_q <= 1'b1;
            state_q    <= ST_IDLE;
          end
        end
        default: begin
          rx_ready_q <= 1'b0;
          bus_req_q  <= 1'b0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.rx_ready   = rx_ready_q;
  assign bus.bus_req    = bus_req_q;
  assign bus.MemRead    = mem_read_q;
  assign bus.MemWrite   = mem_write_q;
  assign bus.Address    = cmd_q.addr;
  assign bus.Write_data = cmd_q.wdata;

endmodule

// File: tb/tb_bus_debug_master.sv
// Testbench for bus_debug_master: directed scenarios plus randomized frames checked
// against a frame-level model (expected responses and a 16-word peripheral image).
module tb_bus_debug_master;
  import dbg_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bus_debug_master_if bus ();

`ifdef DBG_TIMEOUT_EN
  bus_debug_master #(.TIMEOUT_CYCLES(16)) dut (.clk(clk), .rst(rst), .bus(bus));
`else
  bus_debug_master dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  int errors = 0;
  int checks = 0;

  // peripheral stub on the bus, and the model's independent view of it
  logic [31:0] periph  [16];
  logic [31:0] ref_mem [16];
  assign bus.Read_data = periph[bus.Address[3:0]];

  int          wr_cnt = 0, rd_cnt = 0, req_cnt = 0;
  logic [7:0]  tx_q[$];
  logic [31:0] wr_addr_q[$], wr_data_q[$], rd_addr_q[$];
  bit          prev_stall = 0;
  logic [7:0]  prev_data;
  bit          rand_ready = 0, rand_gnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      if (bus.bus_req) req_cnt++;
      if (bus.MemWrite) begin
        wr_cnt++;
        wr_addr_q.push_back(bus.Address);
        wr_data_q.push_back(bus.Write_data);
        periph[bus.Address[3:0]] = bus.Write_data;
      end
      if (bus.MemRead) begin
        rd_cnt++;
        rd_addr_q.push_back(bus.Address);
      end
      if (bus.MemRead || bus.MemWrite) begin
        checks++;
        if (bus.bus_req !== 1'b1) begin
          errors++;
          $display("FAIL strobe_without_req: bus_req=%b required 1", bus.bus_req);
        end
      end
      if (prev_stall) begin
        checks++;
        if (bus.tx_valid !== 1'b1 || bus.tx_data !== prev_data) begin
          errors++;
          $display("FAIL tx_stable: valid=%b data=%h required valid=1 data=%h",
                   bus.tx_valid, bus.tx_data, prev_data);
        end
      end
      prev_stall = bus.tx_valid && !bus.tx_ready;
      prev_data  = bus.tx_data;
      if (bus.tx_valid && bus.tx_ready) tx_q.push_back(bus.tx_data);
    end else begin
      prev_stall = 0;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) bus.tx_ready = 1'($urandom_range(0, 1));
    if (rand_gnt)   bus.bus_gnt  = ($urandom_range(0, 3) == 0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic clear_obs();
    tx_q.delete(); wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
  endtask

  // must be called at a negedge; returns at the negedge after the accepting edge
  task automatic send_byte(input logic [7:0] b, output bit ok);
    int g = 0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (bus.rx_ready !== 1'b1 && g < 300) begin @(negedge clk); g++; end
    ok = (g < 300);
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] fr[$], output bit ok);
    bit b_ok;
    ok = 1;
    foreach (fr[i]) begin
      send_byte(fr[i], b_ok);
      ok &= b_ok;
    end
  endtask

  task automatic wait_tx(input int n, output bit ok);
    int g = 0;
    while (!(tx_q.size() >= n && bus.rx_ready === 1'b1 && bus.tx_valid === 1'b0) && g < 3000) begin
      @(negedge clk); g++;
    end
    ok = (g < 3000);
  endtask

  function automatic void push_word(inout logic [7:0] q[$], input logic [31:0] w);
    for (int i = 3; i >= 0; i--) q.push_back(8'(w >> (8 * i)));
  endfunction

  task automatic test_reset();
    bus.rx_valid = 0; bus.rx_data = 0; bus.tx_ready = 1; bus.bus_gnt = 1;
    for (int i = 0; i < 16; i++) begin
      periph[i]  = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
      ref_mem[i] = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
    end
    rst = 0;
    #23;
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: %b required 0", bus.tx_valid); end
    checks++; if ({bus.bus_req, bus.MemRead, bus.MemWrite, bus.rx_ready} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl: req/rd/wr/rdy=%b required 0000", {bus.bus_req, bus.MemRead, bus.MemWrite, bus.rx_ready}); end
    checks++; if (bus.Address !== 32'h0 || bus.Write_data !== 32'h0 || bus.tx_data !== 8'h0) begin
      errors++; $display("FAIL reset_data: addr=%h wdata=%h tx=%h required 0", bus.Address, bus.Write_data, bus.tx_data); end
    @(negedge clk); rst = 1;
    @(negedge clk);
    checks++; if (bus.rx_ready !== 1'b1) begin errors++; $display("FAIL reset_idle_ready: %b required 1", bus.rx_ready); end
  endtask

  task automatic test_write();
    logic [7:0] fr[$] = '{8'h57, 8'h40, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h0A, 8'h5F};
    bit ok; int wr0;
    clear_obs(); wr0 = wr_cnt; bus.bus_gnt = 1; bus.tx_ready = 1;
    send_frame(fr, ok);
    checks++; if (!ok || bus.bus_req !== 1'b1 || bus.MemWrite !== 1'b0) begin
      errors++; $display("FAIL write_req_latency: ok=%0d req=%b wr=%b required 1 1 0", ok, bus.bus_req, bus.MemWrite); end
    @(negedge clk);
    checks++; if (bus.MemWrite !== 1'b1) begin errors++; $display("FAIL write_strobe_latency: %b required 1", bus.MemWrite); end
    checks++; if (bus.Address !== 32'h4000_0010 || bus.Write_data !== 32'h0000_0A5F) begin
      errors++; $display("FAIL write_bus: addr=%h data=%h required 40000010 00000a5f", bus.Address, bus.Write_data); end
    ref_mem[0] = 32'h0000_0A5F;
    wait_tx(1, ok);
    checks++; if (!ok || tx_q.size() != 1 || tx_q[0] !== RSP_ACK || wr_cnt - wr0 != 1) begin
      errors++; $display("FAIL write_resp: ok=%0d ntx=%0d writes=%0d required 1 byte 4b and 1 write", ok, tx_q.size(), wr_cnt - wr0); end
  endtask

  task automatic test_read();
    logic [7:0] fr[$] = '{8'h52, 8'h40, 8'h00, 8'h00, 8'h10};
    logic [7:0] exp[$];
    bit ok, good; int rd0;
    clear_obs(); rd0 = rd_cnt;
    push_word(exp, ref_mem[0]);
    rand_ready = 1;
    send_frame(fr, ok);
    wait_tx(4, ok);
    rand_ready = 0; bus.tx_ready = 1;
    good = ok && tx_q.size() == 4;
    foreach (exp[i]) if (i < tx_q.size() && tx_q[i] !== exp[i]) good = 0;
    checks++; if (!good) begin errors++; $display("FAIL read_resp: ntx=%0d required 4 bytes %h%h%h%h", tx_q.size(), exp[0], exp[1], exp[2], exp[3]); end
    checks++; if (rd_cnt - rd0 != 1 || rd_addr_q.size() != 1 || rd_addr_q[0] !== 32'h4000_0010) begin
      errors++; $display("FAIL read_strobe: reads=%0d required 1 at 40000010", rd_cnt - rd0); end
  endtask

  task automatic test_bad_opcode();
    logic [7:0] fr[$] = '{8'h33};
    logic [7:0] wf[$] = '{8'h57, 8'h00, 8'h00, 8'h00, 8'h07, 8'hCA, 8'hFE, 8'h12, 8'h34};
    bit ok; int wr0, rd0, rq0;
    clear_obs(); wr0 = wr_cnt; rd0 = rd_cnt; rq0 = req_cnt;
    send_frame(fr, ok);
    wait_tx(1, ok);
    checks++; if (!ok || tx_q.size() != 1 || tx_q[0] !== RSP_ERR) begin
      errors++; $display("FAIL bad_op_resp: ok=%0d ntx=%0d required one byte 45", ok, tx_q.size()); end
    checks++; if (wr_cnt != wr0 || rd_cnt != rd0 || req_cnt != rq0) begin
      errors++; $display("FAIL bad_op_bus: wr=%0d rd=%0d req=%0d required 0 0 0", wr_cnt - wr0, rd_cnt - rd0, req_cnt - rq0); end
    clear_obs();
    send_frame(wf, ok);
    wait_tx(1, ok);
    ref_mem[7] = 32'hCAFE_1234;
    checks++; if (!ok || tx_q.size() != 1 || tx_q[0] !== RSP_ACK || wr_addr_q.size() != 1 || wr_data_q[0] !== 32'hCAFE_1234) begin
      errors++; $display("FAIL bad_op_recovery: ok=%0d ntx=%0d writes=%0d required ack and 1 write", ok, tx_q.size(), wr_addr_q.size()); end
  endtask

  task automatic test_grant_stall();
    logic [7:0] fr[$];
    bit ok, held = 1; int wr0;
    clear_obs(); wr0 = wr_cnt;
    fr.push_back(OP_WRITE); push_word(fr, 32'h0000_0003); push_word(fr, 32'h5A5A_0001);
    bus.bus_gnt = 0;
    send_frame(fr, ok);
    for (int i = 0; i < 20; i++) begin
      if (bus.bus_req !== 1'b1 || bus.MemWrite !== 1'b0) held = 0;
      @(negedge clk);
    end
    checks++; if (!ok || !held || wr_cnt != wr0) begin
      errors++; $display("FAIL grant_stall_hold: ok=%0d held=%0d writes=%0d required 1 1 0", ok, held, wr_cnt - wr0); end
    bus.bus_gnt = 1;
    @(negedge clk);
    checks++; if (bus.MemWrite !== 1'b1) begin errors++; $display("FAIL grant_strobe: %b required 1", bus.MemWrite); end
    bus.bus_gnt = 0;
    @(negedge clk);
    checks++; if (bus.bus_req !== 1'b0 || bus.tx_valid !== 1'b1 || bus.MemWrite !== 1'b0) begin
      errors++; $display("FAIL grant_resp_state: req=%b txv=%b wr=%b required 0 1 0", bus.bus_req, bus.tx_valid, bus.MemWrite); end
    wait_tx(1, ok);
    ref_mem[3] = 32'h5A5A_0001;
    bus.bus_gnt = 1;
    checks++; if (!ok || tx_q.size() != 1 || tx_q[0] !== RSP_ACK || wr_cnt - wr0 != 1) begin
      errors++; $display("FAIL grant_done: ok=%0d ntx=%0d writes=%0d required ack and 1 write", ok, tx_q.size(), wr_cnt - wr0); end
  endtask

  task automatic test_timeout();
    logic [7:0] head[$] = '{8'h57, 8'h40};
    logic [7:0] rest[$];
    bit ok, ok2; int wr0;
    clear_obs(); wr0 = wr_cnt;
    send_frame(head, ok);
    repeat (20) @(negedge clk);
    checks++; if (tx_q.size() != 0 || wr_cnt != wr0 || bus.rx_ready !== 1'b1) begin
      errors++; $display("FAIL timeout_quiet: ntx=%0d writes=%0d rdy=%b required 0 0 1", tx_q.size(), wr_cnt - wr0, bus.rx_ready); end
`ifdef DBG_TIMEOUT_EN
    rest = '{8'h57, 8'h00, 8'h00, 8'h00, 8'h0C, 8'h11, 8'h22, 8'h33, 8'h44};
`else
    rest = '{8'h00, 8'h00, 8'h0C, 8'h11, 8'h22, 8'h33, 8'h44};
`endif
    send_frame(rest, ok2);
    wait_tx(1, ok);
    ref_mem[12] = 32'h1122_3344;
`ifdef DBG_TIMEOUT_EN
    checks++; if (!ok || !ok2 || wr_addr_q.size() != 1 || wr_addr_q[0] !== 32'h0000_000C || wr_data_q[0] !== 32'h1122_3344) begin
      errors++; $display("FAIL timeout_fresh_frame: ok=%0d writes=%0d required 1 write to 0000000c", ok, wr_addr_q.size()); end
`else
    checks++; if (!ok || !ok2 || wr_addr_q.size() != 1 || wr_addr_q[0] !== 32'h4000_000C || wr_data_q[0] !== 32'h1122_3344) begin
      errors++; $display("FAIL stall_completes: ok=%0d writes=%0d required 1 write to 4000000c", ok, wr_addr_q.size()); end
`endif
    checks++; if (tx_q.size() != 1 || tx_q[0] !== RSP_ACK) begin
      errors++; $display("FAIL timeout_resp: ntx=%0d required one byte 4b", tx_q.size()); end
  endtask

  task automatic test_random();
    logic [7:0] fr[$], exp[$];
    logic [31:0] a, d;
    logic [7:0] b;
    int kind, wr0, rd0;
    bit ok, ok2, good;
    rand_ready = 1; rand_gnt = 1;
    for (int f = 0; f < 25; f++) begin
      clear_obs(); fr.delete(); exp.delete();
      wr0 = wr_cnt; rd0 = rd_cnt;
      kind = $urandom_range(0, 4); a = $urandom; d = $urandom;
      if (kind <= 1) begin
        fr.push_back(OP_WRITE); push_word(fr, a); push_word(fr, d); exp.push_back(RSP_ACK);
      end else if (kind <= 3) begin
        fr.push_back(OP_READ); push_word(fr, a); push_word(exp, ref_mem[a[3:0]]);
      end else begin
        b = 8'($urandom_range(0, 255));
        if (b == OP_WRITE || b == OP_READ) b = 8'h00;
        fr.push_back(b); exp.push_back(RSP_ERR);
      end
      send_frame(fr, ok2);
      wait_tx(exp.size(), ok);
      if (kind <= 1) ref_mem[a[3:0]] = d;
      good = ok && ok2 && tx_q.size() == exp.size();
      foreach (exp[i]) if (i < tx_q.size() && tx_q[i] !== exp[i]) good = 0;
      checks++; if (!good) begin
        errors++; $display("FAIL rand_resp[%0d]: kind=%0d ntx=%0d required %0d bytes starting %h", f, kind, tx_q.size(), exp.size(), exp[0]); end
      checks++;
      if ((wr_cnt - wr0) != ((kind <= 1) ? 1 : 0) || (rd_cnt - rd0) != ((kind == 2 || kind == 3) ? 1 : 0) ||
          (kind <= 1 && (wr_addr_q[0] !== a || wr_data_q[0] !== d)) ||
          ((kind == 2 || kind == 3) && rd_addr_q[0] !== a)) begin
        errors++; $display("FAIL rand_bus[%0d]: kind=%0d writes=%0d reads=%0d addr=%h", f, kind, wr_cnt - wr0, rd_cnt - rd0, a);
      end
    end
    rand_ready = 0; rand_gnt = 0;
    @(negedge clk);
    bus.tx_ready = 1; bus.bus_gnt = 1;
  endtask

  task automatic test_reset_mid_resp();
    logic [7:0] fr[$];
    bit ok; int g = 0;
    clear_obs();
    fr.push_back(OP_READ); push_word(fr, 32'h0000_0005);
    bus.bus_gnt = 1; bus.tx_ready = 0;
    send_frame(fr, ok);
    while (bus.tx_valid !== 1'b1 && g < 50) begin @(negedge clk); g++; end
    checks++; if (!ok || g >= 50) begin errors++; $display("FAIL rstmid_resp_start: tx_valid=%b required 1", bus.tx_valid); end
    @(posedge clk); #1 bus.tx_ready = 1;
    @(posedge clk); #1 bus.tx_ready = 0;
    #2 rst = 0;
    #1;
    checks++; if (bus.tx_valid !== 1'b0 || bus.bus_req !== 1'b0 || bus.MemRead !== 1'b0 || bus.MemWrite !== 1'b0 ||
                  bus.Address !== 32'h0 || bus.Write_data !== 32'h0) begin
      errors++; $display("FAIL rstmid_async: txv=%b req=%b addr=%h wdata=%h required all 0", bus.tx_valid, bus.bus_req, bus.Address, bus.Write_data); end
    @(negedge clk); rst = 1;
    @(negedge clk);
    checks++; if (bus.rx_ready !== 1'b1 || bus.tx_valid !== 1'b0 || tx_q.size() != 1) begin
      errors++; $display("FAIL rstmid_idle: rdy=%b txv=%b ntx=%0d required 1 0 1", bus.rx_ready, bus.tx_valid, tx_q.size()); end
    bus.tx_ready = 1;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_bad_opcode();
    test_grant_stall();
    test_timeout();
    test_random();
    test_reset_mid_resp();
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
